modulo_controle_partida: RTL

Game sequencer for the 5×7 LED-matrix naval-battle datapath.
- Loads the preset position matrix, then owns the attack cursor.
- Checks each confirmed shot against the position matrix and commands the write into the attack matrix.
- Counts hits and attempts, and drives the status code (7-seg) and RGB result.
- Sits between the debouncers and the position/attack register matrices, replacing switch-driven sequencing.

---
 rtl/modulo_controle_partida_pkg.sv | 57 +++++
 rtl/modulo_controle_partida_if.sv | 28 ++
 rtl/modulo_detector_borda.sv | 22 ++
 rtl/modulo_controle_partida.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/modulo_controle_partida_pkg.sv
// Shared constants, encodings and cursor helper for the naval-battle game sequencer.
package modulo_controle_partida_pkg;

   localparam int unsigned N_COLS = 5;
   localparam int unsigned N_LINS = 7;

   // Sequencer states
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_CARREGA   = 3'd1;
   localparam logic [2:0] ST_ATAQUE    = 3'd2;
   localparam logic [2:0] ST_VERIFICA  = 3'd3;
   localparam logic [2:0] ST_RESULTADO = 3'd4;
   localparam logic [2:0] ST_FIM       = 3'd5;

   // Status codes shown on the 7-segment display
   localparam logic [1:0] EST_IDLE    = 2'd0;
   localparam logic [1:0] EST_POSICAO = 2'd1;
   localparam logic [1:0] EST_ATAQUE  = 2'd2;
   localparam logic [1:0] EST_FIM     = 2'd3;

   // RGB result codes
   localparam logic [1:0] RGB_NONE    = 2'b00;
   localparam logic [1:0] RGB_ERRO    = 2'b01;
   localparam logic [1:0] RGB_ACERTO  = 2'b10;
   localparam logic [1:0] RGB_VITORIA = 2'b11;

   typedef struct packed {
      logic [2:0] col;
      logic [2:0] lin;
   } cursor_t;

   // Line-major scan: line wraps into the next column, last cell wraps to (0,0)
   function automatic cursor_t cursor_next(input cursor_t c);
      cursor_t n;
      n = c;
      if (c.lin == 3'(N_LINS - 1)) begin
         n.lin = 3'd0;
         n.col = (c.col == 3'(N_COLS - 1)) ? 3'd0 : c.col + 3'd1;
      end else begin
         n.lin = c.lin + 3'd1;
      end
      return n;
   endfunction

   // Status code belonging to each sequencer state
   function automatic logic [1:0] estado_de(input logic [2:0] st);
      logic [1:0] e;
      case (st)
         ST_IDLE:    e = EST_IDLE;
         ST_CARREGA: e = EST_POSICAO;
         ST_FIM:     e = EST_FIM;
         default:    e = EST_ATAQUE;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/modulo_controle_partida_if.sv
// Signal bundle between the game sequencer and the buttons / register matrices.
interface modulo_controle_partida_if;
   logic       btn_confirma;
   logic       btn_conta;
   logic       hit_bit;
   logic       ja_atacado;
   logic [2:0] cur_col;
   logic [2:0] cur_lin;
   logic       po_load;
   logic       at_write;
   logic       mat_clr;
   logic [1:0] estado;
   logic [1:0] rgb;
   logic [3:0] acertos;
   logic [4:0] tentativas;

   modport master (
      input  btn_confirma, btn_conta, hit_bit, ja_atacado,
      output cur_col, cur_lin, po_load, at_write, mat_clr,
             estado, rgb, acertos, tentativas
   );

   modport slave (
      output btn_confirma, btn_conta, hit_bit, ja_atacado,
      input  cur_col, cur_lin, po_load, at_write, mat_clr,
             estado, rgb, acertos, tentativas
   );
endinterface

// File: rtl/modulo_detector_borda.sv
// Registered rising-edge detector; clr preloads history so a held level gives no edge.
module modulo_detector_borda (
   input  logic clk,
   input  logic clr,
   input  logic nivel,
   output logic borda
);

   logic anterior;

   // One-cycle pulse the clock after the level rises
   always_ff @(posedge clk) begin
      if (clr) begin
         anterior <= nivel;
         borda    <= 1'b0;
      end else begin
         anterior <= nivel;
         borda    <= nivel & ~anterior;
      end
   end

endmodule

// File: rtl/modulo_controle_partida.sv
// Game sequencer: loads the preset, drives the attack cursor, scores shots and shows the result.
module modulo_controle_partida
   import modulo_controle_partida_pkg::*;
#(
   parameter int unsigned MAX_TENTATIVAS = 20,
   parameter int unsigned TOTAL_ALVOS    = 6,
   parameter int unsigned HOLD_CICLOS    = 4
) (
   input  logic                      clk,
   input  logic                      clr,
   modulo_controle_partida_if.master bus
);

   localparam int unsigned HOLD_W = (HOLD_CICLOS > 1) ? $clog2(HOLD_CICLOS) : 1;

   logic              borda_conf;
   logic              borda_conta;

   logic [2:0]        st_q,         st_d;
   cursor_t           cur_q,        cur_d;
   logic [3:0]        acertos_q,    acertos_d;
   logic [4:0]        tent_q,       tent_d;
   logic [1:0]        rgb_q,        rgb_d;
   logic [1:0]        estado_q,     estado_d;
   logic [HOLD_W-1:0] hold_q,       hold_d;
   logic              po_load_q,    po_load_d;
   logic              at_write_q,   at_write_d;
   logic              mat_clr_q,    mat_clr_d;

   modulo_detector_borda u_borda_confirma (
      .clk   (clk),
      .clr   (clr),
      .nivel (bus.btn_confirma),
      .borda (borda_conf)
   );

   modulo_detector_borda u_borda_conta (
      .clk   (clk),
      .clr   (clr),
      .nivel (bus.btn_conta),
      .borda (borda_conta)
   );

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (clr) begin
         st_q       <= ST_IDLE;
         cur_q      <= '0;
         acertos_q  <= '0;
         tent_q     <= '0;
         rgb_q      <= RGB_NONE;
         estado_q   <= EST_IDLE;
         hold_q     <= '0;
         po_load_q  <= 1'b0;
         at_write_q <= 1'b0;
         mat_clr_q  <= 1'b0;
      end else begin
         st_q       <= st_d;
         cur_q      <= cur_d;
         acertos_q  <= acertos_d;
         tent_q     <= tent_d;
         rgb_q      <= rgb_d;
         estado_q   <= estado_d;
         hold_q     <= hold_d;
         po_load_q  <= po_load_d;
         at_write_q <= at_write_d;
         mat_clr_q  <= mat_clr_d;
      end
   end

   // Next state and next output values; edges outside IDLE/ATAQUE/FIM are dropped
   always_comb begin
      st_d       = st_q;
      cur_d      = cur_q;
      acertos_d  = acertos_q;
      tent_d     = tent_q;
      rgb_d      = rgb_q;
      hold_d     = hold_q;
      po_load_d  = 1'b0;
      at_write_d = 1'b0;
      mat_clr_d  = 1'b0;

      case (st_q)
         ST_IDLE: begin
            if (borda_conf) begin
               st_d      = ST_CARREGA;
               po_load_d = 1'b1;
               cur_d     = '0;
               acertos_d = '0;
               tent_d    = '0;
               rgb_d     = RGB_NONE;
            end
         end

         ST_CARREGA: begin
            st_d = ST_ATAQUE;
         end

         ST_ATAQUE: begin
            if (borda_conf) begin
               st_d = ST_VERIFICA;
            end else if (borda_conta) begin
               cur_d = cursor_next(cur_q);
            end
         end

         ST_VERIFICA: begin
            if (bus.ja_atacado) begin
               st_d = ST_ATAQUE;
            end else begin
               at_write_d = 1'b1;
               hold_d     = '0;
               st_d       = ST_RESULTADO;
               if (tent_q < 5'(MAX_TENTATIVAS)) begin
                  tent_d = tent_q + 5'd1;
               end
               if (bus.hit_bit) begin
                  rgb_d = RGB_ACERTO;
                  if (acertos_q < 4'(TOTAL_ALVOS)) begin
                     acertos_d = acertos_q + 4'd1;
                  end
               end else begin
                  rgb_d = RGB_ERRO;
               end
            end
         end

         ST_RESULTADO: begin
            if (hold_q == HOLD_W'(HOLD_CICLOS - 1)) begin
               if (acertos_q == 4'(TOTAL_ALVOS)) begin
                  st_d  = ST_FIM;
                  rgb_d = RGB_VITORIA;
               end else if (tent_q == 5'(MAX_TENTATIVAS)) begin
                  st_d  = ST_FIM;
                  rgb_d = RGB_NONE;
               end else begin
                  st_d  = ST_ATAQUE;
                  rgb_d = RGB_NONE;
               end
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end

         ST_FIM: begin
            if (borda_conf) begin
               st_d      = ST_IDLE;
               mat_clr_d = 1'b1;
               rgb_d     = RGB_NONE;
            end
         end

         default: begin
            st_d = ST_IDLE;
         end
      endcase

      estado_d = estado_de(st_d);
   end

   assign bus.cur_col    = cur_q.col;
   assign bus.cur_lin    = cur_q.lin;
   assign bus.po_load    = po_load_q;
   assign bus.at_write   = at_write_q;
   assign bus.mat_clr    = mat_clr_q;
   assign bus.estado     = estado_q;
   assign bus.rgb        = rgb_q;
   assign bus.acertos    = acertos_q;
   assign bus.tentativas = tent_q;

endmodule
